mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 39 +++
 rtl/mem_ctrl.sv | 145 ++++++++++++++
 tb/tb_mem_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared CPU defines for the memory controller: FSM states, load/store
// length codes and byte-lane helpers.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_IF_RD = 2'd1,
    ST_LS_RD = 2'd2,
    ST_LS_WR = 2'd3
  } mc_state_t;

  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd3;

  localparam logic [2:0] FETCH_BYTES = 3'd4;

  // The unused code 2'd2 is treated as a full word.
  function automatic logic [2:0] len_bytes(input logic [1:0] code);
    case (code)
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[{idx, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating instruction fetch and load/store
// onto one 8-bit RAM/IO port.
//
// Handshake: a requester raises its valid with stable address/data and holds
// it until its one-cycle done pulse; no new request is taken while either
// done is high, so the done cycle is always a dead cycle.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        clear,
  input  logic        if_valid,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        lsb_valid,
  input  logic        lsb_wr,
  input  logic [31:0] lsb_addr,
  input  logic [1:0]  lsb_len,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_done,
  output logic [31:0] lsb_rdata
);

  mc_state_t   state;
  logic [2:0]  cnt;
  logic [2:0]  len;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] data;

  logic [31:0] cur_addr;
  logic [1:0]  cap_idx;
  logic [31:0] cap_word;
  logic        is_io;
  logic        wr_fire;

  assign cur_addr = addr + {29'd0, cnt};
  assign cap_idx  = cnt[1:0] - 2'd1;
  assign cap_word = put_byte(data, cap_idx, mem_din);
  assign is_io    = (cur_addr[17:16] == 2'b11);
  assign wr_fire  = rdy_in && !(is_io && io_buffer_full);

  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    case (state)
      ST_IF_RD, ST_LS_RD: begin
        // While frozen, re-present the previous byte address so mem_din
        // still carries the byte the first resumed cycle will capture.
        if (!rdy_in)
          mem_a = (cnt == 3'd0) ? addr : cur_addr - 32'd1;
        else if (cnt < len)
          mem_a = cur_addr;
      end
      ST_LS_WR: begin
        mem_a    = cur_addr;
        mem_dout = get_byte(wdata, cnt[1:0]);
        mem_wr   = wr_fire;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      len       <= '0;
      addr      <= '0;
      wdata     <= '0;
      data      <= '0;
      if_done   <= 1'b0;
      if_data   <= '0;
      lsb_done  <= 1'b0;
      lsb_rdata <= '0;
    end else if (clear && state == ST_IF_RD) begin
      // A branch flush kills the fetch even while frozen.
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (rdy_in) begin
      if_done  <= 1'b0;
      lsb_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!if_done && !lsb_done) begin
            if (lsb_valid) begin
              addr  <= lsb_addr;
              len   <= len_bytes(lsb_len);
              wdata <= lsb_wdata;
              data  <= '0;
              cnt   <= '0;
              state <= lsb_wr ? ST_LS_WR : ST_LS_RD;
            end else if (if_valid && !clear) begin
              addr  <= if_addr;
              len   <= FETCH_BYTES;
              wdata <= '0;
              data  <= '0;
              cnt   <= '0;
              state <= ST_IF_RD;
            end
          end
        end
        ST_IF_RD, ST_LS_RD: begin
          if (cnt != 3'd0)
            data <= cap_word;
          if (cnt == len) begin
            state <= ST_IDLE;
            cnt   <= '0;
            if (state == ST_IF_RD) begin
              if_done <= 1'b1;
              if_data <= cap_word;
            end else begin
              lsb_done  <= 1'b1;
              lsb_rdata <= cap_word;
            end
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        ST_LS_WR: begin
          if (wr_fire) begin
            if (cnt == len - 3'd1) begin
              state    <= ST_IDLE;
              cnt      <= '0;
              lsb_done <= 1'b1;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed and randomized bench for mem_ctrl with a byte-addressed memory
// reference model and latency rules taken from the transfer protocol.
module tb_mem_ctrl;

  localparam int K_FETCH = 0;
  localparam int K_LOAD  = 1;
  localparam int K_STORE = 2;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        clear;
  logic        if_valid;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        lsb_valid;
  logic        lsb_wr;
  logic [31:0] lsb_addr;
  logic [1:0]  lsb_len;
  logic [31:0] lsb_wdata;
  logic        lsb_done;
  logic [31:0] lsb_rdata;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0]  ram     [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  logic [39:0] wr_q[$];
  int          wr_cyc_q[$];
  logic [39:0] exp_q[$];

  mem_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full), .clear(clear),
    .if_valid(if_valid), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .lsb_valid(lsb_valid), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
    .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata)
  );

  // ---------------- clock ----------------
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // ---------------- memory model and write monitor ----------------
  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  function automatic int len_of(input logic [1:0] code);
    return (code == 2'd0) ? 1 : (code == 2'd1) ? 2 : 4;
  endfunction

  always @(posedge clk_in) mem_din <= ram_rd(mem_a);

  always @(negedge clk_in) begin
    if (mem_wr === 1'b1) begin
      ram[mem_a] = mem_dout;
      wr_q.push_back({mem_a, mem_dout});
      wr_cyc_q.push_back(cyc);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram[a]     = b;
    ref_mem[a] = b;
  endtask

  // ---------------- driver: one complete transfer ----------------
  task automatic run_xfer(input string tag, input int kind, input logic [31:0] a,
                          input logic [1:0] lc, input logic [31:0] wd, input int io_stall,
                          input int st_start, input int st_len, input bit clr0);
    int          n, exp_lat, done_at;
    logic        io;
    logic [31:0] exp_data, obs_data;
    n        = (kind == K_FETCH) ? 4 : len_of(lc);
    io       = (a[17:16] == 2'b11);
    exp_lat  = ((kind == K_STORE) ? n + 1 : n + 2) + st_len;
    if (kind == K_STORE && io) exp_lat += io_stall;
    if (kind == K_FETCH && clr0) exp_lat += 1;
    exp_data = '0;
    obs_data = '0;
    exp_q.delete();
    wr_q.delete();
    wr_cyc_q.delete();
    for (int i = 0; i < n; i++) begin
      if (kind == K_STORE) begin
        exp_q.push_back({a + 32'(i), 8'(wd >> (8 * i))});
        ref_mem[a + 32'(i)] = 8'(wd >> (8 * i));
      end else begin
        exp_data[8*i +: 8] = ref_rd(a + 32'(i));
      end
    end
    if (kind == K_FETCH) begin
      if_valid = 1'b1;
      if_addr  = a;
    end else begin
      lsb_valid = 1'b1;
      lsb_wr    = (kind == K_STORE);
      lsb_addr  = a;
      lsb_len   = lc;
      lsb_wdata = wd;
    end
    clear          = clr0;
    rdy_in         = !(st_len > 0 && st_start == 0);
    io_buffer_full = 1'b0;
    done_at        = -1;
    for (int c = 1; c <= 60 && done_at < 0; c++) begin
      @(posedge clk_in);
      #1;
      clear          = 1'b0;
      rdy_in         = !(st_len > 0 && c >= st_start && c < st_start + st_len);
      io_buffer_full = (c <= io_stall);
      #1;
      if (kind == K_STORE && !rdy_in) chk({tag, "/wr_gated_rdy"}, 32'(mem_wr), 32'd0);
      if (kind == K_STORE && io && io_buffer_full) chk({tag, "/wr_gated_io"}, 32'(mem_wr), 32'd0);
      if (((kind == K_FETCH) ? if_done : lsb_done) === 1'b1) begin
        done_at   = c;
        obs_data  = (kind == K_FETCH) ? if_data : lsb_rdata;
        if_valid  = 1'b0;
        lsb_valid = 1'b0;
      end
    end
    if_valid       = 1'b0;
    lsb_valid      = 1'b0;
    rdy_in         = 1'b1;
    io_buffer_full = 1'b0;
    chk({tag, "/latency"}, 32'(done_at), 32'(exp_lat));
    if (kind == K_STORE) begin
      chk({tag, "/wr_count"}, 32'(wr_q.size()), 32'(n));
      for (int i = 0; i < n && i < wr_q.size(); i++) begin
        chk({tag, "/wr_addr"}, wr_q[i][39:8], exp_q[i][39:8]);
        chk({tag, "/wr_data"}, 32'(wr_q[i][7:0]), 32'(exp_q[i][7:0]));
      end
      if (st_len == 0 && !(io && io_stall > 0) && wr_cyc_q.size() == n)
        chk({tag, "/wr_back_to_back"}, 32'(wr_cyc_q[n-1] - wr_cyc_q[0]), 32'(n - 1));
    end else begin
      chk({tag, "/rdata"}, obs_data, exp_data);
      chk({tag, "/no_writes"}, 32'(wr_q.size()), 32'd0);
    end
    @(posedge clk_in);
    #2;
    chk({tag, "/done_one_cycle"}, 32'((kind == K_FETCH) ? if_done : lsb_done), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          l_at, f_at, seen;
    logic [31:0] exp_l, exp_f;

    rst_in = 1'b1; rdy_in = 1'b0; clear = 1'b1; io_buffer_full = 1'b0;
    if_valid = 1'b0; if_addr = '0;
    lsb_valid = 1'b0; lsb_wr = 1'b0; lsb_addr = '0; lsb_len = '0; lsb_wdata = '0;

    // reset wins over rdy_in low and clear high
    repeat (3) @(posedge clk_in);
    #2;
    chk("rst/mem_a", mem_a, 32'd0);
    chk("rst/mem_dout", 32'(mem_dout), 32'd0);
    chk("rst/mem_wr", 32'(mem_wr), 32'd0);
    chk("rst/if_done", 32'(if_done), 32'd0);
    chk("rst/lsb_done", 32'(lsb_done), 32'd0);
    chk("rst/if_data", if_data, 32'd0);
    chk("rst/lsb_rdata", lsb_rdata, 32'd0);
    rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0;
    @(posedge clk_in);
    #2;

    preload(32'h1000, 8'h13); preload(32'h1001, 8'h05);
    preload(32'h1002, 8'h00); preload(32'h1003, 8'h00);
    run_xfer("fetch_1000", K_FETCH, 32'h1000, 2'd3, 32'd0, 0, 0, 0, 1'b0);
    chk("fetch_1000/word", if_data, 32'h0000_0513);

    run_xfer("st_word_200", K_STORE, 32'h200, 2'd3, 32'hDEAD_BEEF, 0, 0, 0, 1'b0);
    run_xfer("st_io_byte", K_STORE, 32'h0003_0000, 2'd0, 32'h0000_0041, 3, 0, 0, 1'b0);
    run_xfer("ld_word_200", K_LOAD, 32'h200, 2'd3, 32'd0, 0, 0, 0, 1'b0);
    chk("ld_word_200/word", lsb_rdata, 32'hDEAD_BEEF);

    // simultaneous requests: LSB first, fetch after the dead cycle
    exp_l = {ref_rd(32'h143), ref_rd(32'h142), ref_rd(32'h141), ref_rd(32'h140)};
    exp_f = 32'h0000_0513;
    lsb_valid = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h140; lsb_len = 2'd3;
    if_valid = 1'b1; if_addr = 32'h1000;
    l_at = -1; f_at = -1;
    for (int c = 1; c <= 40 && f_at < 0; c++) begin
      @(posedge clk_in);
      #2;
      if (lsb_done === 1'b1) begin
        if (l_at < 0) begin
          l_at = c;
          chk("both/lsb_rdata", lsb_rdata, exp_l);
        end
        lsb_valid = 1'b0;
      end
      if (if_done === 1'b1) begin
        f_at = c;
        chk("both/if_data", if_data, exp_f);
        if_valid = 1'b0;
      end
    end
    lsb_valid = 1'b0; if_valid = 1'b0;
    chk("both/lsb_done_cycle", 32'(l_at), 32'd6);
    chk("both/if_done_cycle", 32'(f_at), 32'd13);
    @(posedge clk_in);
    #2;

    // clear in cycle 2 of a fetch
    if_valid = 1'b1; if_addr = 32'h3000;
    @(posedge clk_in); #2;
    @(posedge clk_in); #1; clear = 1'b1; if_valid = 1'b0; #1;
    @(posedge clk_in); #1; clear = 1'b0; #1;
    chk("clr/idle_mem_a", mem_a, 32'd0);
    seen = 0;
    for (int c = 0; c < 7; c++) begin
      if (if_done === 1'b1 || mem_a !== 32'd0) seen = 1;
      @(posedge clk_in);
      #2;
    end
    chk("clr/no_done_stays_idle", 32'(seen), 32'd0);
    run_xfer("fetch_2000", K_FETCH, 32'h2000, 2'd3, 32'd0, 0, 0, 0, 1'b0);
    run_xfer("fetch_clr_idle", K_FETCH, 32'h2000, 2'd3, 32'd0, 0, 0, 0, 1'b1);
    run_xfer("ld_clr_ignored", K_LOAD, 32'h0003_0004, 2'd3, 32'd0, 0, 0, 0, 1'b1);

    // rdy_in freeze mid-load: same data, 4 cycles later
    run_xfer("ld_half_10", K_LOAD, 32'h10, 2'd1, 32'd0, 0, 0, 0, 1'b0);
    run_xfer("ld_half_10_stall", K_LOAD, 32'h10, 2'd1, 32'd0, 0, 2, 4, 1'b0);
    run_xfer("st_stall", K_STORE, 32'h180, 2'd3, 32'hA5A5_0F0F, 0, 2, 3, 1'b0);

    // address wrap across 2^32
    run_xfer("st_wrap", K_STORE, 32'hFFFF_FFFE, 2'd3, 32'h8765_4321, 0, 0, 0, 1'b0);
    run_xfer("ld_wrap", K_LOAD, 32'hFFFF_FFFE, 2'd3, 32'd0, 0, 0, 0, 1'b0);

    // reset aborts a store after its first byte; rdy_in low does not block it
    wr_q.delete();
    lsb_valid = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h400; lsb_len = 2'd3;
    lsb_wdata = 32'h1234_5678;
    @(posedge clk_in); #2;
    @(posedge clk_in); #1; rst_in = 1'b1; rdy_in = 1'b0; #1;
    @(posedge clk_in); #1; rst_in = 1'b0; rdy_in = 1'b1; lsb_valid = 1'b0; #1;
    chk("abort/mem_wr", 32'(mem_wr), 32'd0);
    chk("abort/mem_a", mem_a, 32'd0);
    chk("abort/if_data", if_data, 32'd0);
    chk("abort/lsb_rdata", lsb_rdata, 32'd0);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (lsb_done === 1'b1 || mem_wr === 1'b1) seen = 1;
      @(posedge clk_in);
      #2;
    end
    chk("abort/quiet", 32'(seen), 32'd0);
    chk("abort/wr_count", 32'(wr_q.size()), 32'd1);
    if (wr_q.size() > 0) chk("abort/first_byte", 32'(wr_q[0]), 32'({32'h400, 8'h78}));
    ref_mem[32'h400] = 8'h78;
    run_xfer("ld_abort", K_LOAD, 32'h400, 2'd3, 32'd0, 0, 0, 0, 1'b0);

    // randomized transfers
    for (int t = 0; t < 24; t++) begin
      int          kind, r, sk, ios, ss, sl, n;
      logic [31:0] a;
      logic [1:0]  lc;
      bit          c0;
      kind = int'($urandom_range(0, 2));
      r    = int'($urandom_range(0, 9));
      if (r == 0)      a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else if (r == 1) a = 32'h0003_0000 + 32'($urandom_range(0, 12));
      else             a = 32'h0000_0100 + 32'($urandom_range(0, 60));
      case ($urandom_range(0, 2))
        0:       lc = 2'd0;
        1:       lc = 2'd1;
        default: lc = 2'd3;
      endcase
      n = (kind == K_FETCH) ? 4 : len_of(lc);
      ios = 0; ss = 0; sl = 0; c0 = 1'b0;
      sk = int'($urandom_range(0, 2));
      if (sk == 1) begin
        sl = int'($urandom_range(1, 4));
        ss = int'($urandom_range(0, (kind == K_STORE) ? n : n + 1));
      end else if (sk == 2 && r != 0) begin
        ios = int'($urandom_range(1, 3));
      end else begin
        c0 = ($urandom_range(0, 1) == 1);
      end
      run_xfer($sformatf("rnd%0d", t), kind, a, lc, $urandom, ios, ss, sl, c0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
